// File: rtl/dest_fifo_drain_if.sv
// -----------------------------------------------------------------------------
// dest_fifo_drain_if
//   Bundles the destination-FIFO read side and the delivered-word stream of the
//   D0/D1 drain block.
//
//   master : the drain block (issues pops, drives the stream and status)
//   slave  : the surrounding environment (FIFOs, upstream status, sink)
//
//   Signals
//     init           sync pulse: clear counters, start draining
//     fifo_empty_d0  D0 FIFO empty
//     fifo_empty_d1  D1 FIFO empty
//     data_out_0     D0 FIFO read data, valid the cycle after pop_d0
//     data_out_1     D1 FIFO read data, valid the cycle after pop_d1
//     idle_in        upstream idle indication
//     sink_ready     downstream accepts when valid_out & sink_ready
//     pop_d0/pop_d1  pop requests to the destination FIFOs
//     data_out       delivered word
//     dest_out       source of data_out (0 = D0, 1 = D1)
//     valid_out      data_out/dest_out valid
//     count_d0/_d1   delivered-word counters per destination (wrapping)
//     drained        datapath fully drained
// -----------------------------------------------------------------------------
interface dest_fifo_drain_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
);
    logic              init;
    logic              fifo_empty_d0;
    logic              fifo_empty_d1;
    logic [DATA_W-1:0] data_out_0;
    logic [DATA_W-1:0] data_out_1;
    logic              idle_in;
    logic              sink_ready;

    logic              pop_d0;
    logic              pop_d1;
    logic [DATA_W-1:0] data_out;
    logic              dest_out;
    logic              valid_out;
    logic [CNT_W-1:0]  count_d0;
    logic [CNT_W-1:0]  count_d1;
    logic              drained;

    modport master (
        input  init, fifo_empty_d0, fifo_empty_d1, data_out_0, data_out_1,
               idle_in, sink_ready,
        output pop_d0, pop_d1, data_out, dest_out, valid_out,
               count_d0, count_d1, drained
    );

    modport slave (
        output init, fifo_empty_d0, fifo_empty_d1, data_out_0, data_out_1,
               idle_in, sink_ready,
        input  pop_d0, pop_d1, data_out, dest_out, valid_out,
               count_d0, count_d1, drained
    );
endinterface

// File: rtl/dest_fifo_drain.sv
// -----------------------------------------------------------------------------
// dest_fifo_drain
//   Consumer end of the main-FIFO -> VC -> D0/D1 datapath. Pops the two
//   destination FIFOs round-robin, carries each word through the FIFOs'
//   one-cycle read latency into a 2-entry skid buffer, and presents the buffer
//   head on a valid/ready stream. Counts delivered words per destination and
//   reports when everything upstream and in here has drained.
//
//   Ports
//     clk    single clock, all state on the rising edge
//     reset  asynchronous, active-high; clears all state
//     bus    dest_fifo_drain_if.master (FIFO read side + output stream)
// -----------------------------------------------------------------------------
module dest_fifo_drain #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    dest_fifo_drain_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic              dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           head_q, head_d;          // buffer slot driving the stream
    entry_t           tail_q, tail_d;          // second buffer slot
    logic [1:0]       occ_q, occ_d;            // buffer occupancy 0..2
    logic             inflight_q, inflight_d;  // a pop issued last cycle
    logic             inflight_dest_q, inflight_dest_d;
    logic             last_q, last_d;          // last served: 0 = D0, 1 = D1
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             xfer;
    logic [2:0]       committed;
    logic             room;
    logic             pop0;
    logic             pop1;
    logic             drain_cond;
    entry_t           captured;

    // ------------------------------------------------------------------------
    // Pop arbitration and buffer/counter next state
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default before any branch,
        // otherwise a path that skips the assignment would infer a latch.
        xfer            = (occ_q != 2'd0) && bus.sink_ready;
        pop0            = 1'b0;
        pop1            = 1'b0;
        head_d          = head_q;
        tail_d          = tail_q;
        occ_d           = occ_q;
        cnt0_d          = cnt0_q;
        cnt1_d          = cnt1_q;
        last_d          = last_q;

        // Words already owed a buffer slot (held + in flight), less the one
        // leaving this cycle; a new pop is only safe if a slot stays free.
        committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer};
        room      = (state_q == ST_RUN) && (committed < 3'd2);

        if (room) begin
            if (!bus.fifo_empty_d0 && !bus.fifo_empty_d1) begin
                if (last_q) pop0 = 1'b1;
                else        pop1 = 1'b1;
            end else if (!bus.fifo_empty_d0) begin
                pop0 = 1'b1;
            end else if (!bus.fifo_empty_d1) begin
                pop1 = 1'b1;
            end
        end

        if (pop0)      last_d = 1'b0;
        else if (pop1) last_d = 1'b1;

        inflight_d      = pop0 | pop1;
        inflight_dest_d = pop1;

        // The FIFO read data is valid now for the pop issued last cycle.
        captured.dest = inflight_dest_q;
        captured.data = inflight_dest_q ? bus.data_out_1 : bus.data_out_0;

        unique case ({inflight_q, xfer})
            2'b10: begin
                if (occ_q == 2'd0) head_d = captured;
                else               tail_d = captured;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Capture and transfer together: occupancy holds, queue shifts.
                if (occ_q == 2'd1) begin
                    head_d = captured;
                end else begin
                    head_d = tail_q;
                    tail_d = captured;
                end
            end
            default: ;
        endcase

        if (xfer) begin
            if (head_q.dest) cnt1_d = cnt1_q + CNT_W'(1);
            else             cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (bus.init) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_comb begin
        drain_cond = bus.fifo_empty_d0 && bus.fifo_empty_d1 && bus.idle_in &&
                     !inflight_q && (occ_q == 2'd0);
        state_d    = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.init) state_d = ST_RUN;
            ST_RUN:  if (drain_cond) state_d = ST_DONE;
            ST_DONE: if (!bus.fifo_empty_d0 || !bus.fifo_empty_d1) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
        if (bus.init) state_d = ST_RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            // NOTE: the buffer slots are reset even though occupancy alone
            // qualifies them, so the stream outputs read as zero out of reset.
            head_q          <= '0;
            tail_q          <= '0;
            occ_q           <= 2'd0;
            inflight_q      <= 1'b0;
            inflight_dest_q <= 1'b0;
            last_q          <= 1'b1;   // D0 wins the first tie
            cnt0_q          <= '0;
            cnt1_q          <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q         <= state_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            occ_q           <= occ_d;
            inflight_q      <= inflight_d;
            inflight_dest_q <= inflight_dest_d;
            last_q          <= last_d;
            cnt0_q          <= cnt0_d;
            cnt1_q          <= cnt1_d;
        end
    end

    assign bus.pop_d0    = pop0;
    assign bus.pop_d1    = pop1;
    assign bus.data_out  = head_q.data;
    assign bus.dest_out  = head_q.dest;
    assign bus.valid_out = (occ_q != 2'd0);
    assign bus.count_d0  = cnt0_q;
    assign bus.count_d1  = cnt1_q;
    assign bus.drained   = (state_q == ST_DONE);

endmodule

// File: tb/tb_dest_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_dest_fifo_drain
//   Drives dest_fifo_drain through its interface. Two queue-based destination
//   FIFOs answer the DUT's pops; a queue-level reference model predicts pops,
//   stream contents, counters and drained status every cycle, and directed
//   scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_dest_fifo_drain;

    localparam int DATA_W = 6;
    localparam int CNT_W  = 8;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic clk;
    logic reset;

    dest_fifo_drain_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    dest_fifo_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Environment FIFOs (answer the DUT's actual pops)
    logic [DATA_W-1:0] env_q0[$];
    logic [DATA_W-1:0] env_q1[$];

    // Reference model state
    logic [DATA_W-1:0] m_f0[$];
    logic [DATA_W-1:0] m_f1[$];
    logic [DATA_W:0]   m_pend[$];   // {dest,data}: popped, not yet delivered
    bit                m_infl;      // newest m_pend entry still in the FIFO read stage
    int                m_state;
    bit                m_last;
    logic [CNT_W-1:0]  m_cnt0;
    logic [CNT_W-1:0]  m_cnt1;

    // Per-cycle predictions, computed at the falling edge
    bit e_p0, e_p1, e_xfer, e_drain, e_any, e_valid;
    logic [DATA_W:0] e_head;

    // Observed DUT activity
    bit              rec_p0, rec_p1;
    int              pop_log[$];
    int              pop_cyc[$];
    logic [DATA_W:0] xfer_log[$];
    int              xfer_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_infl  = 1'b0;
        m_state = S_IDLE;
        m_last  = 1'b1;
        m_cnt0  = '0;
        m_cnt1  = '0;
    endtask

    task automatic update_flags();
        bus.fifo_empty_d0 = (env_q0.size() == 0);
        bus.fifo_empty_d1 = (env_q1.size() == 0);
    endtask

    task automatic load(input bit d, input logic [DATA_W-1:0] w);
        if (d) begin env_q1.push_back(w); m_f1.push_back(w); end
        else   begin env_q0.push_back(w); m_f0.push_back(w); end
        update_flags();
    endtask

    task automatic clear_logs();
        pop_log.delete();
        pop_cyc.delete();
        xfer_log.delete();
        xfer_cyc.delete();
    endtask

    // Predict this cycle's outputs from the model, compare, record activity.
    task automatic compare_cycle();
        int vis;
        int owed;
        vis     = m_pend.size() - (m_infl ? 1 : 0);
        e_valid = (vis > 0);
        e_head  = e_valid ? m_pend[0] : '0;
        e_xfer  = e_valid && bus.sink_ready;
        owed    = m_pend.size() - (e_xfer ? 1 : 0);
        e_p0    = 1'b0;
        e_p1    = 1'b0;
        if (!reset && m_state == S_RUN && owed < 2) begin
            if (m_f0.size() != 0 && m_f1.size() != 0) begin
                if (m_last) e_p0 = 1'b1;
                else        e_p1 = 1'b1;
            end else if (m_f0.size() != 0) begin
                e_p0 = 1'b1;
            end else if (m_f1.size() != 0) begin
                e_p1 = 1'b1;
            end
        end
        e_any   = (m_f0.size() != 0) || (m_f1.size() != 0);
        e_drain = !e_any && bus.idle_in && (m_pend.size() == 0);

        check("pop_d0", bus.pop_d0, e_p0);
        check("pop_d1", bus.pop_d1, e_p1);
        check("valid_out", bus.valid_out, e_valid);
        if (e_valid) begin
            check("data_out", bus.data_out, e_head[DATA_W-1:0]);
            check("dest_out", bus.dest_out, e_head[DATA_W]);
        end
        check("count_d0", bus.count_d0, m_cnt0);
        check("count_d1", bus.count_d1, m_cnt1);
        check("drained", bus.drained, (m_state == S_DONE));

        rec_p0 = bus.pop_d0;
        rec_p1 = bus.pop_d1;
        if (bus.pop_d0) begin pop_log.push_back(0); pop_cyc.push_back(cyc); end
        if (bus.pop_d1) begin pop_log.push_back(1); pop_cyc.push_back(cyc); end
        if (bus.valid_out && bus.sink_ready) begin
            xfer_log.push_back({bus.dest_out, bus.data_out});
            xfer_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_cycle();
        end
    end

    task automatic model_update();
        logic [DATA_W:0] w;
        if (reset) begin
            model_reset();
            return;
        end
        if (e_xfer) begin
            w = m_pend.pop_front();
            if (w[DATA_W]) m_cnt1++;
            else           m_cnt0++;
        end
        m_infl = 1'b0;
        if (e_p0) begin
            m_pend.push_back({1'b0, m_f0.pop_front()});
            m_infl = 1'b1;
            m_last = 1'b0;
        end
        if (e_p1) begin
            m_pend.push_back({1'b1, m_f1.pop_front()});
            m_infl = 1'b1;
            m_last = 1'b1;
        end
        case (m_state)
            S_IDLE:  if (bus.init) m_state = S_RUN;
            S_RUN:   if (e_drain)  m_state = S_DONE;
            default: if (e_any)    m_state = S_RUN;
        endcase
        if (bus.init) begin
            m_state = S_RUN;
            m_cnt0  = '0;
            m_cnt1  = '0;
        end
    endtask

    // One clock: after the edge, the FIFOs answer last cycle's pops and the
    // model advances; the caller then applies the next cycle's stimulus.
    task automatic step();
        @(posedge clk);
        #1;
        if (rec_p0 && env_q0.size() != 0) bus.data_out_0 = env_q0.pop_front();
        if (rec_p1 && env_q1.size() != 0) bus.data_out_1 = env_q1.pop_front();
        update_flags();
        model_update();
    endtask

    task automatic pulse_init();
        bus.init = 1'b1;
        step();
        bus.init = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        bus.idle_in = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.drained && m_f0.size() == 0 && m_f1.size() == 0 && m_pend.size() == 0)
                break;
        end
        check(name, bus.drained, 1);
        bus.idle_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        bus.init          = 1'b0;
        bus.data_out_0    = '0;
        bus.data_out_1    = '0;
        bus.idle_in       = 1'b0;
        bus.sink_ready    = 1'b1;
        update_flags();
        model_reset();

        // Reset state
        repeat (3) step();
        #1;
        check("rst_pop_d0", bus.pop_d0, 0);
        check("rst_pop_d1", bus.pop_d1, 0);
        check("rst_valid", bus.valid_out, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_drained", bus.drained, 0);
        reset = 1'b0;
        step();

        // Both FIFOs hold 3 words: strict alternation starting with D0
        pulse_init();
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            load(1'b0, 6'h01 + 6'(i));
            load(1'b1, 6'h11 + 6'(i));
        end
        wait_drained("alt_drained", 40);
        check("alt_pop_count", pop_log.size(), 6);
        for (int i = 0; i < 6 && i < pop_log.size(); i++)
            check($sformatf("alt_pop%0d", i), pop_log[i], i % 2);
        for (int i = 0; i < 6 && i < xfer_log.size(); i++)
            check($sformatf("alt_word%0d", i), xfer_log[i],
                  (i % 2 == 0) ? {1'b0, 6'h01 + 6'(i / 2)} : {1'b1, 6'h11 + 6'(i / 2)});
        if (pop_cyc.size() >= 2 && xfer_cyc.size() >= 1) begin
            check("alt_back_to_back", pop_cyc[1] - pop_cyc[0], 1);
            check("alt_latency", xfer_cyc[0] - pop_cyc[0], 2);
        end
        check("alt_count_d0", bus.count_d0, 3);
        check("alt_count_d1", bus.count_d1, 3);

        // D0 holds 0x2D, 0x2E; D1 empty
        pulse_init();
        clear_logs();
        load(1'b0, 6'h2D);
        load(1'b0, 6'h2E);
        wait_drained("d0_drained", 20);
        check("d0_pop_count", pop_log.size(), 2);
        if (pop_log.size() == 2) begin
            check("d0_pop0_dest", pop_log[0], 0);
            check("d0_pop1_dest", pop_log[1], 0);
            check("d0_pop_spacing", pop_cyc[1] - pop_cyc[0], 1);
        end
        check("d0_xfer_count", xfer_log.size(), 2);
        if (xfer_log.size() == 2) begin
            check("d0_word0", xfer_log[0], 7'h2D);
            check("d0_word1", xfer_log[1], 7'h2E);
            check("d0_latency", xfer_cyc[0] - pop_cyc[0], 2);
        end
        check("d0_count_d0", bus.count_d0, 2);
        check("d0_count_d1", bus.count_d1, 0);

        // Reset mid-stream for 3 cycles after pops D1 then D0
        pulse_init();
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            load(1'b0, 6'h30 + 6'(i));
            load(1'b1, 6'h38 + 6'(i));
        end
        step();
        step();
        check("mid_pre_reset_pops", pop_log.size(), 2);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("mid_rst_pop_d0", bus.pop_d0, 0);
            check("mid_rst_pop_d1", bus.pop_d1, 0);
            check("mid_rst_valid", bus.valid_out, 0);
            check("mid_rst_count_d0", bus.count_d0, 0);
            check("mid_rst_count_d1", bus.count_d1, 0);
            check("mid_rst_drained", bus.drained, 0);
        end
        reset = 1'b0;
        step();
        clear_logs();
        pulse_init();
        wait_drained("mid_drained", 40);
        check("mid_first_pop_d0", (pop_log.size() > 0) ? pop_log[0] : 9, 0);
        check("mid_count_d0", bus.count_d0, 3);
        check("mid_count_d1", bus.count_d1, 3);

        // Sink stalled with 5 words in D0: only 2 pops, head held
        pulse_init();
        clear_logs();
        bus.sink_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(1'b0, 6'h20 + 6'(i));
        repeat (8) step();
        #1;
        check("stall_pops", pop_log.size(), 2);
        check("stall_valid", bus.valid_out, 1);
        check("stall_data", bus.data_out, 6'h20);
        check("stall_dest", bus.dest_out, 0);
        bus.sink_ready = 1'b1;
        wait_drained("stall_drained", 30);
        check("stall_xfer_count", xfer_log.size(), 5);
        for (int i = 0; i < 5 && i < xfer_log.size(); i++)
            check($sformatf("stall_word%0d", i), xfer_log[i], {1'b0, 6'h20 + 6'(i)});
        check("stall_count_d0", bus.count_d0, 5);

        // count_d1 wraps 255 -> 0; count_d0 untouched
        pulse_init();
        load(1'b0, 6'h05);
        for (int i = 0; i < 255; i++) load(1'b1, 6'(i));
        wait_drained("wrap_fill_drained", 400);
        check("wrap_count_d1_255", bus.count_d1, 255);
        check("wrap_count_d0_pre", bus.count_d0, 1);
        load(1'b1, 6'h2A);
        wait_drained("wrap_drained", 20);
        check("wrap_count_d1_0", bus.count_d1, 0);
        check("wrap_count_d0_post", bus.count_d0, 1);

        // DONE, then D1 becomes non-empty
        clear_logs();
        #1;
        check("done_before", bus.drained, 1);
        load(1'b1, 6'h3F);
        step();
        #1;
        check("done_falls", bus.drained, 0);
        check("done_pop_d1", bus.pop_d1, 1);
        check("done_pop_d0", bus.pop_d0, 0);
        wait_drained("done_redrained", 20);
        check("done_xfer_count", xfer_log.size(), 1);
        check("done_word", (xfer_log.size() > 0) ? xfer_log[0] : 7'h00, 7'h7F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
